// File: rtl/mem_arbiter.sv
// Arbitrates the single off-chip line port between icache and dcache.
// Ports: ic_*/dc_* requester sides, mem_* memory side, timeout_o sticky flag.
// Optional build macro: ARB_ROUND_ROBIN_EN (alternate grants on contention).
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 256,
  parameter int TIMEOUT = 1000,
  parameter int CNT_W   = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ic_enable_i,
  input  logic              ic_write_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  input  logic [DATA_W-1:0] ic_data_i,
  output logic              ic_ack_o,
  output logic [DATA_W-1:0] ic_data_o,
  input  logic              dc_enable_i,
  input  logic              dc_write_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [DATA_W-1:0] dc_data_i,
  output logic              dc_ack_o,
  output logic [DATA_W-1:0] dc_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              timeout_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_IC = 2'd1;
  localparam logic [1:0] BUSY_DC = 2'd2;

  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             last_dc;
  logic             pick_dc;
  logic             any_req;
  logic             to_hit;

  always_comb begin
    any_req = ic_enable_i | dc_enable_i;
`ifdef ARB_ROUND_ROBIN_EN
    // On contention the side that did not win last time gets the port.
    pick_dc = dc_enable_i & (~ic_enable_i | ~last_dc);
`else
    pick_dc = dc_enable_i;
`endif
    // Saturate so a hung memory never wraps the counter back under TIMEOUT.
    cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    to_hit   = (TIMEOUT != 0) && (cnt_next == TO_VAL);
  end

  assign ic_ack_o  = (state == BUSY_IC) & mem_ack_i;
  assign dc_ack_o  = (state == BUSY_DC) & mem_ack_i;
  assign ic_data_o = mem_data_i;
  assign dc_data_o = mem_data_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      last_dc      <= 1'b0;
      timeout_o    <= 1'b0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state        <= pick_dc ? BUSY_DC : BUSY_IC;
            mem_enable_o <= 1'b1;
            mem_write_o  <= pick_dc ? dc_write_i : ic_write_i;
            mem_addr_o   <= pick_dc ? dc_addr_i : ic_addr_i;
            mem_data_o   <= pick_dc ? dc_data_i : ic_data_i;
            cnt          <= '0;
          end
        end
        BUSY_IC, BUSY_DC: begin
          if (mem_ack_i) begin
            state        <= IDLE;
            mem_enable_o <= 1'b0;
            cnt          <= '0;
            last_dc      <= (state == BUSY_DC);
          end else begin
            cnt <= cnt_next;
            if (to_hit)
              timeout_o <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          mem_enable_o <= 1'b0;
          cnt          <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// compared against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 256;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_enable_i, ic_write_i, dc_enable_i, dc_write_i;
  logic [AW-1:0] ic_addr_i, dc_addr_i, mem_addr_o;
  logic [DW-1:0] ic_data_i, dc_data_i, ic_data_o, dc_data_o;
  logic [DW-1:0] mem_data_o, mem_data_i;
  logic          ic_ack_o, dc_ack_o, mem_enable_o, mem_write_o;
  logic          mem_ack_i, timeout_o;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .ic_enable_i(ic_enable_i), .ic_write_i(ic_write_i),
    .ic_addr_i(ic_addr_i), .ic_data_i(ic_data_i),
    .ic_ack_o(ic_ack_o), .ic_data_o(ic_data_o),
    .dc_enable_i(dc_enable_i), .dc_write_i(dc_write_i),
    .dc_addr_i(dc_addr_i), .dc_data_i(dc_data_i),
    .dc_ack_o(dc_ack_o), .dc_data_o(dc_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .timeout_o(timeout_o)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Stimulus for the next cycle.
  bit            s_ie, s_iw, s_de, s_dw, s_ak;
  logic [AW-1:0] s_ia, s_da;
  logic [DW-1:0] s_id, s_dd, s_md;

  // Reference: owner 0=none 1=IC 2=DC, the granted command, busy cycles
  // without ack, sticky timeout, and who was served last.
  int            m_own;
  bit            m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_wait;
  bit            m_to;
  int            m_last;

  int grants[$];

  function automatic logic [DW-1:0] r256();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit to_dc;
    if (m_own == 0) begin
      if (s_ie || s_de) begin
`ifdef ARB_ROUND_ROBIN_EN
        to_dc = s_de && (!s_ie || m_last == 1);
`else
        to_dc = s_de;
`endif
        m_own  = to_dc ? 2 : 1;
        m_wr   = to_dc ? s_dw : s_iw;
        m_addr = to_dc ? s_da : s_ia;
        m_data = to_dc ? s_dd : s_id;
        m_wait = 0;
      end
    end else if (s_ak) begin
      m_last = m_own;
      m_own  = 0;
      m_wait = 0;
    end else begin
      m_wait++;
      if (TO != 0 && m_wait >= TO) m_to = 1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    ic_enable_i = s_ie; ic_write_i = s_iw;
    ic_addr_i   = s_ia; ic_data_i  = s_id;
    dc_enable_i = s_de; dc_write_i = s_dw;
    dc_addr_i   = s_da; dc_data_i  = s_dd;
    mem_ack_i   = s_ak; mem_data_i = s_md;
    #1;
    chk("mem_enable", mem_enable_o, m_own != 0);
    if (m_own != 0) begin
      chk("mem_write", mem_write_o, m_wr);
      chk("mem_addr", mem_addr_o, m_addr);
      chk("mem_data", mem_data_o, m_data);
    end
    chk("ic_ack", ic_ack_o, m_own == 1 && s_ak);
    chk("dc_ack", dc_ack_o, m_own == 2 && s_ak);
    if (m_own == 1 && s_ak) chk("ic_data", ic_data_o, s_md);
    if (m_own == 2 && s_ak) chk("dc_data", dc_data_o, s_md);
    chk("timeout", timeout_o, m_to);
    if (ic_ack_o) grants.push_back(1);
    if (dc_ack_o) grants.push_back(2);
    @(posedge clk);
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s_ie = 0; s_iw = 0; s_de = 0; s_dw = 0; s_ak = 0;
    ic_enable_i = 0; dc_enable_i = 0; mem_ack_i = 0;
    #1;
    chk("rst_mem_enable", mem_enable_o, 0);
    chk("rst_mem_write", mem_write_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_data", mem_data_o, 0);
    chk("rst_ic_ack", ic_ack_o, 0);
    chk("rst_dc_ack", dc_ack_o, 0);
    chk("rst_timeout", timeout_o, 0);
    m_own = 0; m_wait = 0; m_to = 0; m_last = 1;
    grants.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_grants(input string tag, input int exp[$]);
    chk({tag, "_count"}, grants.size(), exp.size());
    for (int i = 0; i < exp.size() && i < grants.size(); i++)
      chk(tag, grants[i], exp[i]);
  endtask

  initial begin
    int  e3[$];
    bit  ic_done, dc_done;
    rst = 1'b1;
    s_ia = '0; s_da = '0; s_id = '0; s_dd = '0; s_md = '0;
    ic_write_i = 0; dc_write_i = 0;
    ic_addr_i = '0; dc_addr_i = '0;
    ic_data_i = '0; dc_data_i = '0; mem_data_i = '0;
    do_reset();

    // DC read of 0x100, ack after 10 cycles.
    s_de = 1; s_dw = 0; s_da = 32'h100; s_dd = r256();
    cycle();
    repeat (9) cycle();
    s_ak = 1; s_md = r256();
    cycle();
    s_ak = 0; s_de = 0;
    cycle();
    chk_grants("t1_grants", '{2});

    // Simultaneous request: DC first, IC after the idle gap.
    do_reset();
    s_ie = 1; s_ia = 32'h200; s_id = r256();
    s_de = 1; s_da = 32'h300; s_dd = r256();
    repeat (3) cycle();
    s_ak = 1; s_md = r256();
    cycle();
    s_ak = 0; s_de = 0;
    repeat (3) cycle();
    s_ak = 1; s_md = r256();
    cycle();
    s_ak = 0; s_ie = 0;
    cycle();
    chk_grants("t2_grants", '{2, 1});

    // Both held high across four transactions.
    do_reset();
    s_ie = 1; s_ia = 32'h1000; s_de = 1; s_da = 32'h2000;
    for (int t = 0; t < 4; t++) begin
      repeat (2) cycle();
      s_ak = 1; s_md = r256();
      cycle();
      s_ak = 0;
    end
    s_ie = 0; s_de = 0;
    cycle();
`ifdef ARB_ROUND_ROBIN_EN
    e3 = '{2, 1, 2, 1};
`else
    e3 = '{2, 2, 2, 2};
`endif
    chk_grants("t3_grants", e3);

    // IC write in progress, DC arrives mid-busy and must wait.
    do_reset();
    s_ie = 1; s_iw = 1; s_ia = 32'h40; s_id = {32{8'hA5}};
    repeat (2) cycle();
    s_de = 1; s_dw = 0; s_da = 32'h500; s_dd = r256();
    repeat (3) cycle();
    s_ak = 1; s_md = r256();
    cycle();
    s_ak = 0; s_ie = 0; s_iw = 0;
    repeat (2) cycle();
    s_ak = 1; s_md = r256();
    cycle();
    s_ak = 0; s_de = 0;
    cycle();
    chk_grants("t4_grants", '{1, 2});

    // Random traffic including stale acks while idle.
    do_reset();
    ic_done = 0; dc_done = 0;
    for (int i = 0; i < 600; i++) begin
      if (ic_done) begin
        s_ie = 0; ic_done = 0;
      end else if (!s_ie && $urandom_range(0, 2) == 0) begin
        s_ie = 1; s_iw = 1'($urandom); s_ia = $urandom; s_id = r256();
      end
      if (dc_done) begin
        s_de = 0; dc_done = 0;
      end else if (!s_de && $urandom_range(0, 2) == 0) begin
        s_de = 1; s_dw = 1'($urandom); s_da = $urandom; s_dd = r256();
      end
      s_ak = (m_own != 0) ? ($urandom_range(0, 1) == 0)
                          : ($urandom_range(0, 7) == 0);
      s_md = r256();
      ic_done = (m_own == 1) && s_ak;
      dc_done = (m_own == 2) && s_ak;
      cycle();
    end

    // Timeout: rises after TO busy cycles, survives the ack, clears on reset.
    do_reset();
    s_ie = 0; s_ak = 0;
    s_de = 1; s_dw = 0; s_da = 32'h700; s_dd = r256();
    cycle();
    repeat (12) cycle();
    s_ak = 1; s_md = r256();
    cycle();
    s_ak = 0; s_de = 0;
    cycle();
    chk("t5_timeout_sticky", timeout_o, 1);

    // Reset mid BUSY_DC, then a stale ack.
    do_reset();
    chk("t5_timeout_cleared", timeout_o, 0);
    s_de = 1; s_da = 32'h900; s_dd = r256();
    repeat (3) cycle();
    do_reset();
    s_ak = 1; s_md = r256();
    cycle();
    s_ak = 0;
    cycle();
    chk_grants("t6_grants", '{});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
